alu_mc: RTL and testbench

Parametrised, handshaked, multi-cycle successor to the datapath's combinational integer ALU. It adds XOR, shifts and set-less-than, plus an optional iterative shift-add multiplier. It also adds registered Carry and Overflow flags and a valid/ready interface on both input and output. It sits between the decode/operand stage and writeback in the multi-cycle core and stalls the core through InReady/OutValid.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_mc_comb.sv | 50 +++++
 rtl/alu_mc.sv | 132 +++++++++++++
 tb/tb_alu_mc.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state encoding for alu_mc (state set depends on ALU_MUL_EN)
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;
`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif
endpackage

// File: rtl/alu_mc_comb.sv
// alu_mc_comb: single-cycle function unit producing result, Zero, Carry and Overflow
module alu_mc_comb
  import alu_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         carry,
  output logic         overflow
);
  logic [N:0]     sum;
  logic [N:0]     diff;
  logic [SHW-1:0] sh;
  // decode the op; sub carry is the inverted borrow, unknown codes give zero
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    sh       = b[SHW-1:0];
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (ctrl)
      ALU_ADD: begin
        result   = sum[N-1:0];
        carry    = sum[N];
        overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        result   = diff[N-1:0];
        carry    = ~diff[N];
        overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << sh;
      ALU_SRL:  result = a >> sh;
      ALU_SRA:  result = $signed(a) >>> sh;
      ALU_SLT:  result = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(N-1){1'b0}}, a < b};
      default:  result = '0;
    endcase
    zero = result == '0;
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked multi-cycle ALU; define ALU_MUL_EN to build the iterative multiplier
module alu_mc
  import alu_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         InValid,
  output logic         InReady,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   ALUCtrl,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [N-1:0] ALUResult,
  output logic         Zero,
  output logic         Carry,
  output logic         Overflow,
  output logic         Busy
);
  state_t       state_q, state_d;
  logic [N-1:0] res_q, res_d;
  logic         zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
  logic [N-1:0] c_res;
  logic         c_zero, c_carry, c_ovf;
  logic         accept;

  alu_mc_comb #(.N(N), .SHW(SHW)) u_comb (
    .a(A), .b(B), .ctrl(ALUCtrl),
    .result(c_res), .zero(c_zero), .carry(c_carry), .overflow(c_ovf)
  );

  assign InReady   = (state_q == S_IDLE) || (state_q == S_DONE && OutReady);
  assign accept    = InValid && InReady;
  assign OutValid  = state_q == S_DONE;
  assign ALUResult = res_q;
  assign Zero      = zero_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;

`ifdef ALU_MUL_EN
  localparam int CW = SHW + 1;
  logic [N-1:0]  mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_sum;
  logic [CW-1:0] cnt_q, cnt_d;
  assign Busy = state_q == S_EXEC;
`else
  assign Busy = 1'b0;
`endif

  // next state: accept from IDLE/consumed DONE, iterate shift-add in EXEC, drop to IDLE once consumed
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    if (accept) begin
`ifdef ALU_MUL_EN
      if (ALUCtrl == ALU_MUL) begin
        state_d  = S_EXEC;
        mcand_d  = A;
        mplier_d = B;
        acc_d    = '0;
        cnt_d    = CW'(N);
      end else
`endif
      begin
        state_d = S_DONE;
        res_d   = c_res;
        zero_d  = c_zero;
        carry_d = c_carry;
        ovf_d   = c_ovf;
      end
    end
`ifdef ALU_MUL_EN
    else if (state_q == S_EXEC) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = S_DONE;
        res_d   = acc_sum;
        zero_d  = acc_sum == '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
    end
`endif
    else if (state_q == S_DONE && OutReady) begin
      state_d = S_IDLE;
    end
  end

  // state and output registers; async reset discards any in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (both ALU_MUL_EN builds)
module tb_alu_mc;
  import alu_pkg::*;
  localparam int N = 32;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic [3:0]   ctrl = '0;
  logic         in_ready, out_valid, zero, carry, ovf, busy;
  logic [N-1:0] res;
  int           errors = 0, checks = 0;

  typedef struct packed {
    logic [3:0]   op;
    logic [N-1:0] a, b, r;
    logic         z, c, v;
  } vec_t;

  localparam vec_t VECS [12] = '{
    '{ALU_SRA,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 1'b0},
    '{ALU_SLTU, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 1'b0},
    '{ALU_SLT,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0},
    '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0},
    '{ALU_OR,   32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0},
    '{ALU_SLL,  32'd1,        32'd33,       32'd2,        1'b0, 1'b0, 1'b0},
    '{ALU_SRL,  32'h80000000, 32'd31,       32'd1,        1'b0, 1'b0, 1'b0},
    '{ALU_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0},
    '{ALU_SUB,  32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b1},
    '{ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b1, 1'b0},
    '{4'hF,     32'd12,       32'd34,       32'd0,        1'b1, 1'b0, 1'b0},
    '{ALU_XOR,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'd0,        1'b1, 1'b0, 1'b0}
  };

  alu_mc #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(in_valid), .InReady(in_ready),
    .A(a), .B(b), .ALUCtrl(ctrl), .OutValid(out_valid), .OutReady(out_ready),
    .ALUResult(res), .Zero(zero), .Carry(carry), .Overflow(ovf), .Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] op, input logic [N-1:0] a_i, input logic [N-1:0] b_i);
    ctrl = op; a = a_i; b = b_i; in_valid = 1'b1;
  endtask

  task automatic out_chk(input string tag, input logic [N-1:0] r, input logic z, input logic c, input logic v);
    chk(tag, {out_valid, zero, carry, ovf, res}, {1'b1, z, c, v, r});
  endtask

  initial begin
    int n, busy_cnt;
    logic seen;
    step(); step();
    chk("reset_out", {in_ready, out_valid, busy, zero, carry, ovf, res}, {1'b1, 5'b0, 32'd0});
    rst_n = 1'b1;
    step(); step();
    chk("idle_no_valid", out_valid, 1'b0);

    out_ready = 1'b1;
    put(ALU_ADD, 32'h7FFFFFFF, 32'd1);
    step();
    out_chk("add_ovf", 32'h80000000, 1'b0, 1'b0, 1'b1);
    put(ALU_SUB, 32'd5, 32'd5);
    step();
    out_chk("sub_eq", 32'd0, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    chk("consumed_hold", {out_valid, zero, res}, {1'b0, 1'b1, 32'd0});

    for (int i = 0; i < 12; i++) begin
      put(VECS[i].op, VECS[i].a, VECS[i].b);
      step();
      out_chk($sformatf("stream_%0d", i), VECS[i].r, VECS[i].z, VECS[i].c, VECS[i].v);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", out_valid, 1'b0);

    out_ready = 1'b0;
    put(ALU_XOR, 32'h0000FF00, 32'h00000FF0);
    step();
    put(ALU_ADD, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_%0d", i), {in_ready, out_valid, res}, {1'b0, 1'b1, 32'h0000F0F0});
      step();
    end
    out_ready = 1'b1;
    step();
    out_chk("bp_next", 32'd2, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    step();
    chk("bp_drain", out_valid, 1'b0);

`ifdef ALU_MUL_EN
    put(ALU_MUL, 32'hFFFFFFFF, 32'd3);
    step();
    in_valid = 1'b0;
    chk("exec_inready", {in_ready, busy}, 2'b01);
    n = 1;
    busy_cnt = 0;
    while (!out_valid && n < 200) begin
      busy_cnt += busy;
      step();
      n++;
    end
    chk("mul_latency", n, N + 1);
    chk("mul_busy", busy_cnt, N);
    out_chk("mul_res", 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
`else
    put(ALU_MUL, 32'hFFFFFFFF, 32'd3);
    step();
    in_valid = 1'b0;
    out_chk("mul_off", 32'd0, 1'b1, 1'b0, 1'b0);
    chk("mul_off_busy", busy, 1'b0);
`endif
    step();

    out_ready = 1'b0;
`ifdef ALU_MUL_EN
    put(ALU_MUL, 32'd7, 32'd6);
`else
    put(ALU_ADD, 32'd7, 32'd6);
`endif
    step();
    in_valid = 1'b0;
    repeat (9) step();
`ifdef ALU_MUL_EN
    chk("mid_busy", {busy, out_valid}, 2'b10);
`else
    chk("mid_busy", {busy, out_valid}, 2'b01);
`endif
    rst_n = 1'b0;
    #1;
    chk("mid_reset", {in_ready, out_valid, busy, zero, carry, ovf, res}, {1'b1, 5'b0, 32'd0});
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (N + 4) begin
      step();
      seen |= out_valid;
    end
    chk("no_lost_valid", seen, 1'b0);
    put(ALU_ADD, 32'd2, 32'd3);
    step();
    in_valid = 1'b0;
    out_chk("add_after_rst", 32'd5, 1'b0, 1'b0, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
